// File: rtl/slave_port_initiator.sv
// slave_port_initiator: issues single read/write accesses on one lane (CH) of
// the packed multi-channel slave memory port of an accelerator top, and
// returns read data or a write acknowledge on a valid/ready response channel.
// One access is outstanding at a time: IDLE accepts, ISSUE drives the lane
// until Sout_DataRdy[CH], RESP holds the response until it is consumed.
// Optional feature macro: SLAVE_PORT_INITIATOR_TIMEOUT_EN adds an ISSUE
// watchdog that ends the access with rsp_err=1 after TIMEOUT_CYCLES cycles.
module slave_port_initiator #(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 64,
  parameter int SIZE_W         = 7,
  parameter int CHANNELS       = 2,
  parameter int CH             = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_we,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_wdata,
  input  logic [SIZE_W-1:0]            cmd_size,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [CHANNELS-1:0]          S_oe_ram,
  output logic [CHANNELS-1:0]          S_we_ram,
  output logic [CHANNELS*ADDR_W-1:0]   S_addr_ram,
  output logic [CHANNELS*DATA_W-1:0]   S_Wdata_ram,
  output logic [CHANNELS*SIZE_W-1:0]   S_data_ram_size,
  input  logic [CHANNELS*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [CHANNELS-1:0]          Sout_DataRdy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state_q, state_d;

  // Registered outputs and their next values
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              oe_q,        oe_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [SIZE_W-1:0] size_q,      size_d;

  logic              accept;
  logic              lane_rdy;
  logic [DATA_W-1:0] lane_rdata;
  logic              timeout_hit;

  // Bits of each access size that carry data; sizes at or above the lane
  // width keep the whole lane.
  function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] size);
    logic [DATA_W-1:0] one;
    one = DATA_W'(1);
    if (int'(size) >= DATA_W) return '1;
    return (one << size) - one;
  endfunction

  function automatic logic legal_size(input logic [SIZE_W-1:0] size);
    return (size == SIZE_W'(8))  || (size == SIZE_W'(16)) ||
           (size == SIZE_W'(32)) || (size == SIZE_W'(64));
  endfunction

  assign accept     = cmd_valid && cmd_ready_q;
  assign lane_rdy   = Sout_DataRdy[CH];
  assign lane_rdata = Sout_Rdata_ram[CH*DATA_W +: DATA_W];

  // Other lanes of the read bus belong to other initiators and are ignored.
  logic unused_lanes;
  assign unused_lanes = ^{Sout_Rdata_ram, Sout_DataRdy};

`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A DataRdy on the limit edge still wins, so the hit is gated by !lane_rdy.
  assign timeout_hit = (state_q == ISSUE) && !lane_rdy &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter of ISSUE cycles
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every always_comb output is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = legal_size(cmd_size) ? ISSUE : RESP;
      ISSUE:   if (lane_rdy || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    oe_d        = oe_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_ready_d = 1'b0;
          if (legal_size(cmd_size)) begin
            oe_d    = !cmd_we;
            we_d    = cmd_we;
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata & size_mask(cmd_size);
            size_d  = cmd_size;
`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            // Illegal size: answer with an error, never touch the bus.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      ISSUE: begin
        if (lane_rdy || timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = !lane_rdy;
          rsp_rdata_d = (lane_rdy && !we_q) ? (lane_rdata & size_mask(size_q)) : '0;
          oe_d        = 1'b0;
          we_d        = 1'b0;
          addr_d      = '0;
          wdata_d     = '0;
          size_d      = '0;
        end
`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers; reset also aborts any in-flight bus access
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      oe_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Place the lane registers on lane CH of the packed bus; other lanes stay 0
  always_comb begin
    S_oe_ram                              = '0;
    S_we_ram                              = '0;
    S_addr_ram                            = '0;
    S_Wdata_ram                           = '0;
    S_data_ram_size                       = '0;
    S_oe_ram[CH]                          = oe_q;
    S_we_ram[CH]                          = we_q;
    S_addr_ram[CH*ADDR_W +: ADDR_W]       = addr_q;
    S_Wdata_ram[CH*DATA_W +: DATA_W]      = wdata_q;
    S_data_ram_size[CH*SIZE_W +: SIZE_W]  = size_q;
  end

endmodule

// File: tb/tb_slave_port_initiator.sv
// Testbench for slave_port_initiator: directed commands, a responder model
// for lane 0 of the slave bus, and a scoreboard monitor that checks every
// response handshake against hand-computed expected values.
module tb_slave_port_initiator;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 64;
  localparam int SIZE_W   = 7;
  localparam int CHANNELS = 2;
`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic                       clock;
  logic                       reset;
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_we;
  logic [ADDR_W-1:0]          cmd_addr;
  logic [DATA_W-1:0]          cmd_wdata;
  logic [SIZE_W-1:0]          cmd_size;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [DATA_W-1:0]          rsp_rdata;
  logic                       rsp_err;
  logic [CHANNELS-1:0]        S_oe_ram;
  logic [CHANNELS-1:0]        S_we_ram;
  logic [CHANNELS*ADDR_W-1:0] S_addr_ram;
  logic [CHANNELS*DATA_W-1:0] S_Wdata_ram;
  logic [CHANNELS*SIZE_W-1:0] S_data_ram_size;
  logic [CHANNELS*DATA_W-1:0] Sout_Rdata_ram;
  logic [CHANNELS-1:0]        Sout_DataRdy;

  slave_port_initiator #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
    .CHANNELS(CHANNELS), .CH(0), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
  );

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  rsp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int pushed   = 0;
  int rsp_count = 0;
  int we01_cnt = 0;
  int oe01_cnt = 0;
  int bus_cnt  = 0;
  int rise_cyc = 0;
  int accept_cyc = 0;
  int slave_delay = 1;
  logic [DATA_W-1:0] slave_rdata = '0;

  // Monitor history
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_reset = 1'b1;
  logic [63:0] prev_rdata = '0;
  logic        prev_err   = 1'b0;
  rsp_t        exp_r;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Lane-0 slave responder: DataRdy rises in the slave_delay-th ISSUE cycle
  // (0 means never). Lane 1 carries noise that must be ignored, and DataRdy
  // on lane 0 is high whenever the lane is idle.
  initial begin
    int issue_n;
    issue_n = 0;
    Sout_DataRdy   = 2'b11;
    Sout_Rdata_ram = {64'hBADB_ADBA_DBAD_BAD0, 64'h0};
    forever begin
      @(posedge clock);
      #1;
      if (S_oe_ram[0] || S_we_ram[0]) issue_n++;
      else issue_n = 0;
      Sout_DataRdy[1] = 1'b1;
      Sout_DataRdy[0] = (issue_n == 0) ? 1'b1 :
                        ((slave_delay != 0) && (issue_n >= slave_delay));
      Sout_Rdata_ram  = {64'hBADB_ADBA_DBAD_BAD0, slave_rdata};
    end
  end

  // Scoreboard monitor
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (S_oe_ram != 2'b00 || S_we_ram != 2'b00) bus_cnt++;
      if (S_we_ram == 2'b01) we01_cnt++;
      if (S_oe_ram == 2'b01) oe01_cnt++;
      check("oe_we_exclusive", S_oe_ram & S_we_ram, 2'b00);
      if (!prev_reset && prev_valid && !prev_ready) begin
        check("rsp_hold_valid", rsp_valid, 1'b1);
        check("rsp_hold_rdata", rsp_rdata, prev_rdata);
        check("rsp_hold_err", rsp_err, prev_err);
      end
      if (rsp_valid && !prev_valid) rise_cyc = cyc;
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", sb_q.size(), 1);
        end else begin
          exp_r = sb_q.pop_front();
          check("rsp_rdata", rsp_rdata, exp_r.rdata);
          check("rsp_err", rsp_err, exp_r.err);
        end
        rsp_count++;
      end
    end
    prev_valid = reset ? 1'b0 : rsp_valid;
    prev_ready = rsp_ready;
    prev_rdata = rsp_rdata;
    prev_err   = rsp_err;
    prev_reset = reset;
  end

  // Present one command until accepted; on acceptance optionally push the
  // expected response. Returns just after the accepting edge.
  task automatic send_cmd(input logic we, input logic [8:0] addr,
                          input logic [63:0] wdata, input logic [6:0] size,
                          input int delay, input logic [63:0] rdata,
                          input logic push, input logic [63:0] exp_rdata,
                          input logic exp_err);
    logic got;
    got         = 1'b0;
    slave_delay = delay;
    slave_rdata = rdata;
    cmd_valid   = 1'b1;
    cmd_we      = we;
    cmd_addr    = addr;
    cmd_wdata   = wdata;
    cmd_size    = size;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      if (cmd_ready) begin
        got        = 1'b1;
        accept_cyc = cyc;
        if (push) begin
          sb_q.push_back('{rdata: exp_rdata, err: exp_err});
          pushed++;
        end
      end
      @(posedge clock);
      #1;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", got, 1'b1);
  endtask

  // Wait until every pushed response has been consumed, then step past the
  // handshake edge.
  task automatic wait_rsp();
    for (int i = 0; i < 300 && rsp_count < pushed; i++) @(negedge clock);
    check("rsp_count", rsp_count, pushed);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int base_we, base_oe, base_bus, base_rsp, a3, a4;
    logic seen;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_size  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_rdata", rsp_rdata, 64'h0);
    check("reset_rsp_err", rsp_err, 1'b0);
    check("reset_bus", {S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size}, 0);
    check("reset_wdata", S_Wdata_ram, 128'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // 64-bit write, DataRdy in the 3rd ISSUE cycle
    base_we = we01_cnt; base_oe = oe01_cnt;
    send_cmd(1'b1, 9'h010, 64'h0123_4567_89AB_CDEF, 7'd64, 3, 64'h0,
             1'b1, 64'h0, 1'b0);
    @(negedge clock);
    check("wr_we", S_we_ram, 2'b01);
    check("wr_oe", S_oe_ram, 2'b00);
    check("wr_addr", S_addr_ram, {9'h000, 9'h010});
    check("wr_wdata", S_Wdata_ram, {64'h0, 64'h0123_4567_89AB_CDEF});
    check("wr_size", S_data_ram_size, {7'd0, 7'd64});
    wait_rsp();
    check("wr_we_cycles", we01_cnt - base_we, 3);
    check("wr_oe_cycles", oe01_cnt - base_oe, 0);

    // 8-bit read, upper bits of lane data must be dropped
    base_we = we01_cnt; base_oe = oe01_cnt;
    send_cmd(1'b0, 9'h010, 64'h0, 7'd8, 2, 64'hFFFF_FFFF_FFFF_FFA5,
             1'b1, 64'h0000_0000_0000_00A5, 1'b0);
    wait_rsp();
    check("rd8_oe_cycles", oe01_cnt - base_oe, 2);
    check("rd8_we_cycles", we01_cnt - base_we, 0);
    check("rd8_oe_idle", S_oe_ram, 2'b00);

    // Back-to-back reads, DataRdy in the first ISSUE cycle, rsp_ready tied 1
    send_cmd(1'b0, 9'h020, 64'h0, 7'd16, 1, 64'h1122_3344_5566_7788,
             1'b1, 64'h0000_0000_0000_7788, 1'b0);
    a3 = accept_cyc;
    send_cmd(1'b0, 9'h024, 64'h0, 7'd32, 1, 64'h1122_3344_5566_7788,
             1'b1, 64'h0000_0000_5566_7788, 1'b0);
    a4 = accept_cyc;
    check("b2b_latency_first", rise_cyc - a3, 2);
    check("b2b_spacing", a4 - a3, 3);
    wait_rsp();
    check("b2b_latency_second", rise_cyc - a4, 2);

    // 8-bit write: write data masked to the size on the bus
    send_cmd(1'b1, 9'h031, 64'hFFFF_FFFF_FFFF_FF3C, 7'd8, 1, 64'h0,
             1'b1, 64'h0, 1'b0);
    @(negedge clock);
    check("wr8_wdata", S_Wdata_ram, {64'h0, 64'h0000_0000_0000_003C});
    check("wr8_size", S_data_ram_size, {7'd0, 7'd8});
    check("wr8_we", S_we_ram, 2'b01);
    wait_rsp();

    // Response back-pressure: hold for 5 cycles with a new command waiting
    rsp_ready = 1'b0;
    send_cmd(1'b0, 9'h040, 64'h0, 7'd64, 2, 64'hDEAD_BEEF_CAFE_F00D,
             1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 9'h048;
    cmd_size  = 7'd16;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = rsp_valid;
    end
    check("hold_rsp_seen", seen, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("hold_cmd_ready", cmd_ready, 1'b0);
      check("hold_rdata", rsp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    rsp_ready = 1'b1;
    send_cmd(1'b0, 9'h048, 64'h0, 7'd16, 2, 64'hDEAD_BEEF_CAFE_F00D,
             1'b1, 64'h0000_0000_0000_F00D, 1'b0);
    wait_rsp();

    // Illegal size: error response, no bus activity
    base_bus = bus_cnt;
    send_cmd(1'b0, 9'h050, 64'h0, 7'd12, 1, 64'h1234_5678_9ABC_DEF0,
             1'b1, 64'h0, 1'b1);
    wait_rsp();
    check("illegal_no_bus", bus_cnt - base_bus, 0);

    // Reset in the middle of ISSUE aborts the access without a response
    base_rsp = rsp_count;
    send_cmd(1'b0, 9'h060, 64'h0, 7'd64, 0, 64'h5555_6666_7777_8888,
             1'b0, 64'h0, 1'b0);
    @(negedge clock);
    check("abort_pre_oe", S_oe_ram, 2'b01);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_oe", S_oe_ram, 2'b00);
    check("abort_we", S_we_ram, 2'b00);
    check("abort_bus", {S_addr_ram, S_data_ram_size}, 0);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_cmd_ready", cmd_ready, 1'b1);
    repeat (4) @(negedge clock);
    check("abort_no_rsp", rsp_count, base_rsp);
    @(posedge clock);
    #1;

    // Normal operation after the abort
    send_cmd(1'b0, 9'h070, 64'h0, 7'd32, 1, 64'hA5A5_A5A5_1234_5678,
             1'b1, 64'h0000_0000_1234_5678, 1'b0);
    wait_rsp();

`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
    // Watchdog: DataRdy never arrives, lane drops after 4 ISSUE cycles
    base_oe = oe01_cnt;
    send_cmd(1'b0, 9'h080, 64'h0, 7'd32, 0, 64'hFFFF_0000_FFFF_0000,
             1'b1, 64'h0, 1'b1);
    wait_rsp();
    check("timeout_oe_cycles", oe01_cnt - base_oe, 4);
    check("timeout_oe_idle", S_oe_ram, 2'b00);
`endif

    repeat (2) @(negedge clock);
    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/slave_port_initiator.md
Name: slave_port_initiator

Overview:
- Initiator for the slave memory port (S_oe_ram/S_we_ram/S_addr_ram/S_Wdata_ram/S_data_ram_size -> Sout_Rdata_ram/Sout_DataRdy) of an HLS-generated accelerator top.
- The simulation harness uses it to preload inputs and read back results without touching the accelerator's internal memories.
- Accepts single read/write commands on a valid/ready interface, drives one channel of the packed multi-channel slave bus, and returns read data or a write acknowledge on a valid/ready response interface.

Parameters:
- ADDR_W, 9, address bits per channel
- DATA_W, 64, data bits per channel
- SIZE_W, 7, access-size field width per channel, in bits
- CHANNELS, 2, number of packed channels on the slave bus
- CH, 0, channel index this instance drives; all other lanes are driven 0
- TIMEOUT_CYCLES, 255, watchdog limit (used only with the optional feature)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_we  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_size  in  SIZE_W  access size in bits (8/16/32/64)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
- rsp_rdata  out  DATA_W  read data, zero-extended above size; 0 for writes
- rsp_err  out  1  1=timeout or illegal size
- S_oe_ram  out  CHANNELS  read enable per channel
- S_we_ram  out  CHANNELS  write enable per channel
- S_addr_ram  out  CHANNELS*ADDR_W  packed addresses
- S_Wdata_ram  out  CHANNELS*DATA_W  packed write data
- S_data_ram_size  out  CHANNELS*SIZE_W  packed sizes
- Sout_Rdata_ram  in  CHANNELS*DATA_W  packed read data
- Sout_DataRdy  in  CHANNELS  per-channel completion

Behaviour:
- All outputs are registered. On reset: state IDLE; cmd_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; all S_* outputs 0.
- Reset asserted in any state aborts an in-flight access: S_oe/S_we drop the next cycle and no response is produced.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - cmd_ready=1.
  - Accept with legal size (8/16/32/64): latch the command; cmd_ready=0; go to ISSUE. Lane CH gets addr, size, and wdata masked to size (bits >= size zeroed). S_we_ram[CH]=cmd_we; S_oe_ram[CH]=!cmd_we.
  - Accept with illegal size: no bus activity; go to RESP with rsp_err=1 and rsp_rdata=0.
- ISSUE:
  - Lane CH is held stable until Sout_DataRdy[CH] is sampled 1 at a posedge.
  - On that edge: capture Sout_Rdata_ram lane CH masked to size (reads) or 0 (writes); rsp_err=0; clear S_oe/S_we/addr/wdata/size; go to RESP.
  - Minimum latency cmd accept -> rsp_valid is 2 cycles, when DataRdy is high in the first ISSUE cycle.
  - Sout_DataRdy on any other lane, or outside ISSUE, is ignored.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_ready.
  - On handshake: rsp_valid=0; cmd_ready=1; go to IDLE.
  - No new command is accepted while in RESP. Throughput is one command per response, with at most one outstanding.
- S_oe_ram and S_we_ram are never both 1, and never 1 outside ISSUE.
- Size masking: mask = (size>=DATA_W) ? all ones : (1<<size)-1.
- Address passes through unmodified; alignment is the caller's responsibility.

Optional Feature:
- SLAVE_PORT_INITIATOR_TIMEOUT_EN
- Defined:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle.
  - When it reaches TIMEOUT_CYCLES without DataRdy: drop S_oe/S_we, go to RESP with rsp_err=1 and rsp_rdata=0.
  - DataRdy arriving on the same edge the limit is reached wins, giving a normal response.
- Undefined: no counter; ISSUE waits indefinitely; rsp_err is set only for illegal size.

Test Plan:
- Write addr=0x010, size=64, wdata=0x0123_4567_89AB_CDEF, DataRdy after 3 cycles -> S_we_ram=2'b01 held exactly 3 cycles; S_Wdata lane0 = that value; lane1 = 0; rsp_valid, rsp_err=0, rsp_rdata=0.
- Read addr=0x010, size=8, Sout_Rdata lane0=0xFFFF_FFFF_FFFF_FFA5 -> rsp_rdata=0x0000_0000_0000_00A5; S_oe_ram high only during ISSUE.
- DataRdy already high in first ISSUE cycle, rsp_ready tied 1 -> rsp_valid 2 cycles after accept; back-to-back commands, one per 3 cycles.
- rsp_ready held 0 for 5 cycles after response -> rsp_valid and rsp_rdata stable; cmd_ready=0; new cmd_valid ignored until handshake.
- cmd_size=12 -> no S_oe/S_we pulse; rsp_err=1; rsp_rdata=0. Reset mid-ISSUE -> next cycle all S_* = 0, rsp_valid=0, cmd_ready=1.
- With SLAVE_PORT_INITIATOR_TIMEOUT_EN, TIMEOUT_CYCLES=4, DataRdy never asserted -> S_oe_ram drops after 4 ISSUE cycles; rsp_err=1.
